// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : 8-bit UART receiver, 1 start / 8 data LSB-first / 1 stop,    |
// |               sticky frame/overrun/parity flags. Define UART_RX_PARITY_EN  |
// |               to insert an even-parity bit between data and stop.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  input  logic       i_read,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             sync1, sync2;
  logic [1:0]       settle;
  logic             armed;
  logic             complete;
  logic             set_frame;
`ifdef UART_RX_PARITY_EN
  logic             set_parity;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
    end
  end

  // The synchronizer powers up high, so a line already low after reset would
  // look like a falling edge. Start detection waits until the flops hold real
  // line samples and one of them was high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & sync2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
    complete   = 1'b0;
    set_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
    set_parity = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (armed && !sync2) begin
          state_nxt = START;
          cnt_nxt   = HALF_LAST;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else if (sync2) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
          cnt_nxt   = BIT_LAST;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          shift_nxt = {sync2, shift[7:1]};
          cnt_nxt   = BIT_LAST;
          if (bit_idx == 3'd7) begin
            bit_nxt   = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          set_parity = (^shift) != sync2;
          cnt_nxt    = BIT_LAST;
          state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          cnt_nxt = '0;
          if (sync2) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            set_frame = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (sync2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completion while an unread byte is held drops the new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (complete && (!o_valid || i_read)) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (i_read) begin
        o_valid <= 1'b0;
      end
      o_frame_err <= set_frame | (o_frame_err & ~i_read);
      o_overrun   <= (complete & o_valid & ~i_read) | (o_overrun & ~i_read);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_parity_err <= 1'b0;
    else        o_parity_err <= set_parity | (o_parity_err & ~i_read);
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Randomized scoreboard bench for uart_rx (CLKS_PER_BIT=16); honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT_MAX = 156 + P * C;
  localparam int RD_OFF  = 3 + C / 2 + (9 + P) * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd;
  logic [7:0] data;
  logic       valid, frame_err, overrun, parity_err;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx         (rx),
    .i_read       (rd),
    .o_data       (data),
    .o_valid      (valid),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .o_parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit         m_valid, m_fe, m_ov, m_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what a receiver holding at most one byte must report per frame.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad, input bit rd_same);
    if (rd_same) begin m_fe = 0; m_ov = 0; m_pe = 0; end
    if (par_bad) m_pe = 1;
    if (!stop_ok) m_fe = 1;
    else if (!m_valid || rd_same) begin exp_q.push_back(b); m_valid = 1; end
    else m_ov = 1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (P == 1) q.push_back((^b) ^ par_bad);
    q.push_back(stop_ok);
    foreach (q[i]) begin
      @(negedge clk);
      rx = q[i];
      repeat (C - 1) @(negedge clk);
    end
  endtask

  task automatic do_read();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_valid = 0; m_fe = 0; m_ov = 0; m_pe = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"},  valid,      m_valid);
    check({tag, "_frame"},  frame_err,  m_fe);
    check({tag, "_ovr"},    overrun,    m_ov);
    check({tag, "_parity"}, parity_err, m_pe);
  endtask

  // Monitor: every new byte presentation must match the scoreboard head.
  initial begin
    bit         pv = 0;
    logic [7:0] pd = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset && valid && (!pv || data != pd)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected none", data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", data, e);
        end
      end
      pv = valid;
      pd = data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rx = 1'b1; rd = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check_state("rst");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 latency, then read clears valid next cycle
    model_frame(8'hA5, 1, 0, 0);
    n = 0;
    fork
      send_frame(8'hA5, 1, 0);
      begin
        do begin @(negedge clk); n++; end while (!valid && n < 400);
      end
    join
    checks++;
    if (n > LAT_MAX) begin
      errors++;
      $display("FAIL a5_latency: %0d cycles, required <= %0d", n, LAT_MAX);
    end
    check("a5_data", data, 8'hA5);
    check_state("a5");
    do_read();
    check_state("a5_read");

    // 8-cycle glitch on idle line
    @(negedge clk); rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    check_state("glitch");

    // bad stop bit followed by a long break, then a good frame
    model_frame(8'h3C, 0, 0, 0);
    send_frame(8'h3C, 0, 0);
    repeat (39 * C) @(negedge clk);
    check_state("break");
    rx = 1'b1;
    repeat (C) @(negedge clk);
    model_frame(8'h55, 1, 0, 0);
    send_frame(8'h55, 1, 0);
    check("after_break_data", data, 8'h55);
    check_state("after_break");
    do_read();
    check_state("after_break_read");

    // overrun, then read coincident with completion
    model_frame(8'h11, 1, 0, 0);
    send_frame(8'h11, 1, 0);
    model_frame(8'h22, 1, 0, 0);
    send_frame(8'h22, 1, 0);
    check("ovr_data", data, 8'h11);
    check_state("ovr");
    model_frame(8'h33, 1, 0, 1);
    fork
      send_frame(8'h33, 1, 0);
      begin
        repeat (RD_OFF) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    check("coinc_data", data, 8'h33);
    check_state("coinc");
    do_read();

    // reset during data bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1, 0);
      begin
        repeat (1 + 5 * C + C / 2) @(negedge clk);
        reset = 1'b0;
        m_valid = 0; m_fe = 0; m_ov = 0; m_pe = 0;
        #1;
        check("midrst_data", data, 8'h00);
        check_state("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (C) @(negedge clk);
    model_frame(8'h81, 1, 0, 0);
    send_frame(8'h81, 1, 0);
    check("post_rst_data", data, 8'h81);
    check_state("post_rst");
    do_read();

`ifdef UART_RX_PARITY_EN
    model_frame(8'h07, 1, 1, 0);
    send_frame(8'h07, 1, 1);
    check("par_data", data, 8'h07);
    check_state("par");
    do_read();
`endif

    // randomized frames with random gaps and skipped reads
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit         pb;
      b  = 8'($urandom);
      pb = (P == 1) && ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3 * C)) @(negedge clk);
      model_frame(b, 1, pb, 0);
      send_frame(b, 1, pb);
      check_state("rand");
      if ($urandom_range(0, 3) != 0) do_read();
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are integers >= 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_rx  input  1  serial line, idles high, asynchronous to clk.
REQ-005 SHALL have port i_read  input  1  one-cycle pulse that consumes the held byte and clears the error flags.
REQ-006 SHALL have port o_data  output  8  last received byte.
REQ-007 SHALL have port o_valid  output  1  high while an unread byte is held.
REQ-008 SHALL have port o_frame_err  output  1  sticky flag: a stop bit was sampled low.
REQ-009 SHALL have port o_overrun  output  1  sticky flag: a byte completed while o_valid was high and unread.
REQ-010 SHALL have port o_parity_err  output  1  sticky flag: parity mismatch (see Configuration).

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer reset to 1; only the synchronized value is used.
REQ-012 Frame format SHALL be 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-014 IDLE->START SHALL occur on a synchronized low; the bit counter then loads CLKS_PER_BIT/2-1.
REQ-015 In START at counter 0, the synchronized line SHALL be sampled:
- high: glitch, return to IDLE, no flag change.
- low: go to DATA with the counter at CLKS_PER_BIT-1.
REQ-016 In DATA, the line SHALL be sampled every CLKS_PER_BIT cycles into a shift register (MSB-in, right shift); after 8 samples go to PARITY if enabled, else STOP.
REQ-017 In STOP, the line SHALL be sampled once after CLKS_PER_BIT cycles:
- high: complete the frame.
- low: set o_frame_err, discard the byte, go to WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL return to IDLE on the first synchronized high (break handling).
REQ-019 On frame completion with o_valid=0 or i_read=1 in the same cycle, o_data SHALL load the byte and o_valid SHALL be 1 on the next cycle.
REQ-020 On frame completion with o_valid=1 and i_read=0, o_overrun SHALL set, the new byte SHALL be dropped, and o_data SHALL be unchanged.
REQ-021 i_read with o_valid=1 and no completion in the same cycle SHALL clear o_valid on the next cycle.
REQ-022 i_read SHALL clear o_frame_err, o_overrun and o_parity_err on the next cycle; a flag set in that same cycle SHALL win over the clear.
REQ-023 i_read with o_valid=0 SHALL have no effect other than clearing the flags.
REQ-024 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap outside 0..CLKS_PER_BIT-1.
REQ-025 o_data SHALL remain stable while o_valid=1, except on a simultaneous read-and-complete.

Reset
REQ-026 reset low SHALL immediately force:
- FSM to IDLE, synchronizer flops to 1, counters and shift register to 0;
- o_data=0x00 and o_valid, o_frame_err, o_overrun, o_parity_err to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no flag set.
REQ-028 After release, the remainder of an aborted frame SHALL only start a new frame on a genuine high-to-low transition.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL control the parity feature.
REQ-030 With UART_RX_PARITY_EN defined:
- the PARITY state SHALL sample one even-parity bit after the 8 data bits;
- a mismatch SHALL set o_parity_err while the byte is still delivered per REQ-019/020.
REQ-031 Without UART_RX_PARITY_EN:
- the PARITY state SHALL be unreachable and DATA SHALL go directly to STOP;
- o_parity_err SHALL be tied to 0.

Verification
REQ-032 Bench SHALL cover: CLKS_PER_BIT=16, byte 0xA5 sent 8N1 -> o_data=0xA5 and o_valid=1 within 156 cycles of the start edge; i_read -> o_valid=0 next cycle.
REQ-033 Bench SHALL cover: an 8-cycle low glitch on idle i_rx -> FSM back to IDLE, o_valid=0, all flags 0.
REQ-034 Bench SHALL cover: 0x3C sent with its stop bit low and the line held low for 40 bit times -> o_frame_err=1, o_valid=0; the following 0x55 frame is received correctly once the line returns high.
REQ-035 Bench SHALL cover: 0x11 then 0x22 sent with no i_read -> o_data=0x11 and o_overrun=1; then i_read timed in the completion cycle of 0x33 -> o_data=0x33, o_valid=1, o_overrun=0.
REQ-036 Bench SHALL cover: reset pulsed low during data bit 4 of 0xFF -> all outputs 0; the next 0x81 frame is received correctly.
REQ-037 Bench SHALL cover, with UART_RX_PARITY_EN defined: 0x07 sent with parity bit 0 -> o_data=0x07, o_valid=1, o_parity_err=1.
